pe_edge_source: RTL



---
 rtl/pe_edge_source_pkg.sv | 25 ++
 rtl/pe_edge_source_word_fifo.sv | 85 ++++++++
 rtl/pe_edge_source.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pe_edge_source_pkg.sv
// Shared definitions for the PE mesh boundary blocks.
//   - default word geometry ({addr,data}) and the MAX_INT pad word
//   - phase encoding used by pe_edge_source (and future edge collectors)
package pe_edge_source_pkg;

   localparam int ADDR_WIDTH_DEF = 3;
   localparam int DATA_WIDTH_DEF = 3;
   localparam int WORD_W         = ADDR_WIDTH_DEF + DATA_WIDTH_DEF;

   // Pad word: all ones, so the boundary never wins a PE comparison.
   localparam logic [WORD_W-1:0] MAX_INT_DEF = 6'b111_111;

   typedef enum logic [0:0] {
      PH_SORT    = 1'b0,
      PH_COMPUTE = 1'b1
   } phase_e;

   // Width of a counter able to hold 0..max(a,b)-1 (never narrower than 1 bit).
   function automatic int cyc_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pe_edge_source_word_fifo.sv
// pe_word_fifo: synchronous DEPTH-entry word FIFO with wrap-around pointers.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_wdata   push request and word; ignored while full
//   i_pop             pop request; ignored while empty
//   o_rdata           word at the read pointer (valid when not empty)
//   o_count           occupancy 0..DEPTH
//   o_full, o_empty   status decoded from the registered occupancy
// Full/empty come from the registered count, so a push while full is dropped
// even if a pop happens on the same edge, and a word pushed into an empty
// FIFO cannot be popped on the edge that writes it.
module pe_word_fifo #(
   parameter  int WIDTH = 6,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_s;
   logic             pop_s;

   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_empty = (count_q == {CNT_W{1'b0}});
   assign push_s  = i_push & ~o_full;
   assign pop_s   = i_pop & ~o_empty;
   assign o_rdata = mem_q[rd_ptr_q];
   assign o_count = count_q;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = i_wdata;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/pe_edge_source.sv
// pe_edge_source: drives one PE neighbour input at the mesh boundary.
// Words pushed by a loader are queued and presented on o_PE for one compute
// phase each; during sort phases, or when nothing is queued, o_PE carries
// MAX_INT so the boundary never wins a comparison.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_en           phase advance enable (low freezes FSM and o_PE)
//   i_valid/i_word push handshake, {addr,data}; independent of i_en
//   o_ready        queue can accept a push (combinational from count)
//   o_PE           word into the PE input, o_word_valid marks a real word
//   o_phase        0 = SORT, 1 = COMPUTE
//   o_count        queue occupancy
module pe_edge_source
   import pe_edge_source_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT =
      (ADDR_WIDTH+DATA_WIDTH)'(MAX_INT_DEF),
   parameter int SORT_CYCLES    = 1,
   parameter int COMPUTE_CYCLES = 1,
   parameter int DEPTH          = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_en,
   input  logic                             i_valid,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_word,
   output logic                             o_ready,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
   output logic                             o_word_valid,
   output logic                             o_phase,
   output logic [$clog2(DEPTH):0]           o_count
);

   localparam int W     = ADDR_WIDTH + DATA_WIDTH;
   localparam int CYC_W = cyc_width(SORT_CYCLES, COMPUTE_CYCLES);

   phase_e           phase_q, phase_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [W-1:0]     pe_q, pe_d;
   logic             wv_q, wv_d;
   logic             pop_s;
   logic [W-1:0]     head_s;
   logic             full_s;
   logic             empty_s;
   logic             sort_last_s;
   logic             comp_last_s;

   pe_word_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (i_valid),
      .i_wdata (i_word),
      .i_pop   (pop_s),
      .o_rdata (head_s),
      .o_count (o_count),
      .o_full  (full_s),
      .o_empty (empty_s)
   );

   assign sort_last_s  = (cyc_q == CYC_W'(SORT_CYCLES - 1));
   assign comp_last_s  = (cyc_q == CYC_W'(COMPUTE_CYCLES - 1));
   assign o_ready      = ~full_s;
   assign o_PE         = pe_q;
   assign o_word_valid = wv_q;
   assign o_phase      = phase_q;

   // Phase state register and presented-word registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= PH_SORT;
         cyc_q   <= {CYC_W{1'b0}};
         pe_q    <= MAX_INT;
         wv_q    <= 1'b0;
      end else begin
         phase_q <= phase_d;
         cyc_q   <= cyc_d;
         pe_q    <= pe_d;
         wv_q    <= wv_d;
      end
   end

   // Next phase and cycle-within-phase counter.
   always_comb begin
      phase_d = phase_q;
      cyc_d   = cyc_q;
      if (i_en) begin
         case (phase_q)
            PH_SORT: begin
               if (sort_last_s) begin
                  phase_d = PH_COMPUTE;
                  cyc_d   = {CYC_W{1'b0}};
               end else begin
                  cyc_d = cyc_q + CYC_W'(1);
               end
            end
            PH_COMPUTE: begin
               if (comp_last_s) begin
                  phase_d = PH_SORT;
                  cyc_d   = {CYC_W{1'b0}};
               end else begin
                  cyc_d = cyc_q + CYC_W'(1);
               end
            end
            default: begin
               phase_d = PH_SORT;
               cyc_d   = {CYC_W{1'b0}};
            end
         endcase
      end else begin
         phase_d = phase_q;
         cyc_d   = cyc_q;
      end
   end

   // Output word selection; the single pop of a round happens on the
   // SORT->COMPUTE edge and only if a word was already queued.
   always_comb begin
      pe_d  = pe_q;
      wv_d  = wv_q;
      pop_s = 1'b0;
      if (i_en) begin
         case (phase_q)
            PH_SORT: begin
               if (sort_last_s && !empty_s) begin
                  pop_s = 1'b1;
                  pe_d  = head_s;
                  wv_d  = 1'b1;
               end else begin
                  pe_d = MAX_INT;
                  wv_d = 1'b0;
               end
            end
            PH_COMPUTE: begin
               if (comp_last_s) begin
                  pe_d = MAX_INT;
                  wv_d = 1'b0;
               end else begin
                  pe_d = pe_q;
                  wv_d = wv_q;
               end
            end
            default: begin
               pe_d = MAX_INT;
               wv_d = 1'b0;
            end
         endcase
      end else begin
         pe_d = pe_q;
         wv_d = wv_q;
      end
   end

endmodule
